// File: rtl/b_ram.sv
// rtl/b_ram.sv - simple dual-port RAM, port A write, port B registered read (read-first)
// Optional second output stage: define B_RAM_OUT_REG_EN (read latency 2).
module b_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              clkb,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  // clkb exists only for port compatibility; everything runs on clka
  logic w_unused_clkb;
  assign w_unused_clkb = clkb;

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic              w_wr_hit;
  logic              w_rd_hit;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_dout1;

  assign w_wr_hit  = wea && ({1'b0, addra} < LIMIT);
  assign w_rd_hit  = {1'b0, addrb} < LIMIT;
  assign w_rd_data = w_rd_hit ? r_mem[addrb] : '0;

  // Memory has no reset so writes proceed while rst_n is low
  always_ff @(posedge clka) begin
    if (w_wr_hit) begin
      r_mem[addra] <= dina;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_dout1 <= '0;
    end else begin
      r_dout1 <= w_rd_data;
    end
  end

`ifdef B_RAM_OUT_REG_EN
  logic [DATA_W-1:0] r_dout2;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_dout2 <= '0;
    end else begin
      r_dout2 <= r_dout1;
    end
  end

  assign doutb = r_dout2;
`else
  assign doutb = r_dout1;
`endif

endmodule

// File: tb/tb_b_ram.sv
// tb/tb_b_ram.sv - directed and model-checked bench for b_ram
module tb_b_ram;

`ifdef B_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  addra;
  logic [15:0] dina;
  logic        wea;
  logic [3:0]  addrb;
  logic [15:0] doutb;

  int total;
  int bad;

  logic [15:0] ref_mem [16];
  logic [15:0] exp_hist [64];

  b_ram #(.ADDR_W(4), .DATA_W(16)) dut (
    .clka  (clk),
    .rst_n (rst_n),
    .clkb  (clk),
    .addra (addra),
    .dina  (dina),
    .wea   (wea),
    .addrb (addrb),
    .doutb (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    addra = a;
    dina  = d;
    wea   = 1'b1;
    tick(1);
    wea   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    addrb = a;
    tick(LAT);
    chk(tag, doutb, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    rst_n = 1'b1;
    addra = 4'd0;
    dina  = 16'h0000;
    wea   = 1'b0;
    addrb = 4'd0;
    #1 rst_n = 1'b0;
    #1 chk("reset_dout", doutb, 16'h0000);

    // write performed while reset is held
    @(posedge clk); #1;
    wr(4'd9, 16'h0909);
    chk("reset_dout_hold", doutb, 16'h0000);
    rst_n = 1'b1;

    rd_chk("unwritten_7", 4'd7, 16'h0000);

    wr(4'd3, 16'hA5A5);
    rd_chk("wr3_rd3", 4'd3, 16'hA5A5);

    // read-first collision on address 5
    wr(4'd5, 16'h1111);
    addra = 4'd5;
    dina  = 16'h2222;
    wea   = 1'b1;
    addrb = 4'd5;
    tick(1);
    wea   = 1'b0;
    ref_mem[5] = 16'h2222;
    if (LAT > 1) tick(LAT - 1);
    chk("collision_old", doutb, 16'h1111);
    tick(1);
    chk("collision_new", doutb, 16'h2222);

    wr(4'd2, 16'h0202);
    addra = 4'd2;
    dina  = 16'hFFFF;
    wea   = 1'b0;
    tick(1);
    rd_chk("wea0_keep2", 4'd2, 16'h0202);

    wr(4'd6, 16'h0001);
    wr(4'd6, 16'h0002);
    rd_chk("b2b_last6", 4'd6, 16'h0002);

    rd_chk("during_reset_wr9", 4'd9, 16'h0909);

    // asynchronous reset pulse mid-cycle
    rd_chk("pre_pulse3", 4'd3, 16'hA5A5);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_zero", doutb, 16'h0000);
    #1 rst_n = 1'b1;
    #1 chk("reset_released_still0", doutb, 16'h0000);
    tick(1);
    if (LAT > 1) tick(LAT - 1);
    chk("post_pulse3", doutb, 16'hA5A5);

    // random writes every cycle, sweeping reads with read-first model
    for (int i = 0; i < 48; i++) begin
      addra = 4'($urandom_range(0, 15));
      dina  = 16'($urandom);
      wea   = 1'b1;
      addrb = 4'(i % 16);
      exp_hist[i] = ref_mem[addrb];
      ref_mem[addra] = dina;
      tick(1);
      if (i >= LAT - 1) chk("random_sweep", doutb, exp_hist[i - LAT + 1]);
    end
    wea = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/b_ram.md
B_RAM -- requirements
Module: b_ram

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, address width of both ports.
REQ-002 The block SHALL have parameter DATA_W, default 16, word width.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_W, number of words; DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port clka, input, 1, the single block clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 The block SHALL have port clkb, input, 1; it is present for port-B compatibility only, SHALL be driven from the same source as clka, and SHALL clock no logic.
REQ-007 The block SHALL have port addra, input, ADDR_W, write address.
REQ-008 The block SHALL have port dina, input, DATA_W, write data.
REQ-009 The block SHALL have port wea, input, 1, write enable, active-high.
REQ-010 The block SHALL have port addrb, input, ADDR_W, read address.
REQ-011 The block SHALL have port doutb, output, DATA_W, registered read data.

Function
REQ-012 The block SHALL be a simple dual-port RAM of DEPTH x DATA_W: port A write-only, port B read-only.
REQ-013 On a rising edge with wea=1 and addra<DEPTH, mem[addra] SHALL take dina; with wea=0 the memory SHALL be unchanged.
REQ-014 A write with addra>=DEPTH SHALL be ignored.
REQ-015 On every rising edge outside reset, doutb SHALL take mem[addrb]; read latency is 1 cycle; there is no read enable.
REQ-016 A read with addrb>=DEPTH SHALL return 0.
REQ-017 Same-edge write and read of one address SHALL be read-first: doutb returns the old word, and the new word is readable from the next edge.
REQ-018 Back-to-back writes to one address SHALL leave the last written value.
REQ-019 Addresses SHALL NOT wrap; the address is used as an unsigned index.
REQ-020 Memory contents SHALL be 0 at power-up (initialised at configuration).
REQ-021 Unknown (X) bits on addra while wea=1 SHALL NOT corrupt any other word in RTL simulation.

Reset
REQ-022 While rst_n=0, doutb SHALL be 0, asynchronously, independent of clka.
REQ-023 Reset SHALL NOT alter memory contents; writes with wea=1 SHALL still be performed during reset.
REQ-024 After rst_n deasserts, the first rising edge SHALL load doutb with mem[addrb].
REQ-025 With rst_n left undriven or held high, the block SHALL operate normally.

Configuration
REQ-026 With macro B_RAM_OUT_REG_EN defined, a second output register SHALL be added: read latency 2, both stages reset to 0, read-first collision preserved relative to the first stage.
REQ-027 Without B_RAM_OUT_REG_EN, the read latency SHALL be 1 as in REQ-015.

Verification
REQ-028 Bench SHALL cover: write 0xA5A5 to addr 3; read addr 3 next cycle -> doutb=0xA5A5 one edge later (two edges later with B_RAM_OUT_REG_EN).
REQ-029 Bench SHALL cover: read addr 7 before any write -> doutb=0x0000.
REQ-030 Bench SHALL cover: mem[5]=0x1111, same edge write 0x2222 to 5 and read 5 -> doutb=0x1111, next read -> 0x2222.
REQ-031 Bench SHALL cover: wea=0, dina=0xFFFF, addra=2 -> mem[2] unchanged (read back prior value).
REQ-032 Bench SHALL cover: rst_n pulsed low mid-cycle while doutb=0xA5A5 -> doutb=0 immediately; after release, the stored word is read back intact.
REQ-033 Bench SHALL cover: random addra/dina with wea=1 each cycle and addrb sweeping 0..15 with wrap in the bench -> every doutb matches the reference model.
